// File: rtl/lcd_pkg.sv
// Purpose     : command codes, FSM state encoding and helpers shared by lcd_host.
// Latency     : none; types and constants only.
// Backpressure: none.
// Ports       : none (package).
package lcd_pkg;

  // LCD controller command codes; 12-15 are reserved and never reach the controller.
  typedef enum logic [3:0] {
    WRITE       = 4'd0,
    SHIFT_UP    = 4'd1,
    SHIFT_DOWN  = 4'd2,
    SHIFT_LEFT  = 4'd3,
    SHIFT_RIGHT = 4'd4,
    MAX         = 4'd5,
    MIN         = 4'd6,
    AVERAGE     = 4'd7,
    ROTATE_CCW  = 4'd8,
    ROTATE_CW   = 4'd9,
    MIRROR_X    = 4'd10,
    MIRROR_Y    = 4'd11
  } cmd_e;

  localparam logic [3:0] CMD_MAX  = 4'd11;
  localparam logic [6:0] CAP_FULL = 7'd64;  // pixels expected back after a Write

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ISSUE,
    GUARD,
    WAIT_DONE,
    FINISH
  } state_e;

  function automatic logic is_legal(input logic [3:0] code);
    return code <= CMD_MAX;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Purpose     : generic synchronous FIFO with fall-through head (rd_data = current head).
// Latency     : a write is visible at rd_data the cycle after it is accepted.
// Backpressure: writes dropped while full unless a read fires in the same cycle.
// Ports       : clk/reset; wr_en/wr_data push; rd_en pop with rd_data head; full/empty status.
module lcd_cmd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8  // power of two, >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign rd_fire = rd_en && !empty;
  // A pop frees the slot this cycle, so a concurrent push is safe even when full.
  assign wr_fire = wr_en && (!full || rd_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_host.sv
// Purpose     : LCD host: image ROM/result RAM responders plus a command FIFO sequencer.
// Latency     : IROM_Q/rd_data combinational; a queued command issues 1 cycle after busy=0 seen.
// Backpressure: cmd_in_ready low while the FIFO is full; issue stalls on busy or empty FIFO.
// Ports       : img_wr_* ROM load; cmd_in/_valid/_ready push; start; rd_addr/rd_data readback;
//               seq_done/err_illegal/err_short sticky flags; cmd/cmd_valid/busy/done to controller;
//               IROM_* image-ROM responder; IRAM_* result-RAM responder.
module lcd_host
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       img_wr_en,
  input  logic [5:0] img_wr_addr,
  input  logic [7:0] img_wr_data,
  input  logic [3:0] cmd_in,
  input  logic       cmd_in_valid,
  output logic       cmd_in_ready,
  input  logic       start,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       seq_done,
  output logic       err_illegal,
  output logic       err_short,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  input  logic       IROM_rd,
  input  logic [5:0] IROM_A,
  output logic [7:0] IROM_Q,
  input  logic       IRAM_valid,
  input  logic [5:0] IRAM_A,
  input  logic [7:0] IRAM_D
);

  logic [7:0] rom [64];
  logic [7:0] res [64];
  logic [6:0] cap_cnt;
  logic [3:0] issued;
  logic [3:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       push_legal;
  logic       pop;
  logic       wd_enter;
  logic       done_hit;
  state_e     state;
  state_e     state_next;

  // Image ROM and result buffer: serviced in every state, contents survive reset.
  always_ff @(posedge clk) begin
    if (img_wr_en) rom[img_wr_addr] <= img_wr_data;
  end

  always_ff @(posedge clk) begin
    if (IRAM_valid) res[IRAM_A] <= IRAM_D;
  end

  assign IROM_Q  = IROM_rd ? rom[IROM_A] : 8'h00;
  assign rd_data = res[rd_addr];

  // Reserved codes complete the handshake but are discarded and flagged.
  assign cmd_in_ready = !fifo_full;
  assign push         = cmd_in_valid && cmd_in_ready;
  assign push_legal   = push && is_legal(cmd_in);

  lcd_cmd_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_legal),
    .wr_data (cmd_in),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 4'h0;
    case (state)
      IDLE:      if (start) state_next = WAIT_RDY;
      WAIT_RDY:  if (!busy && !fifo_empty) state_next = ISSUE;
      ISSUE: begin
        pop        = 1'b1;
        // Masked during reset so an aborted sequence never leaks a last pulse.
        cmd_valid  = !reset;
        cmd        = reset ? 4'h0 : fifo_head;
        state_next = GUARD;
      end
      GUARD:     state_next = (issued == WRITE) ? WAIT_DONE : WAIT_RDY;
      WAIT_DONE: if (done) state_next = FINISH;
      FINISH:    state_next = FINISH;
      default:   state_next = IDLE;
    endcase
  end

  assign wd_enter = (state == GUARD) && (state_next == WAIT_DONE);
  assign done_hit = (state == WAIT_DONE) && done;

  always_ff @(posedge clk) begin
    if (reset) begin
      issued      <= 4'h0;
      cap_cnt     <= 7'd0;
      seq_done    <= 1'b0;
      err_illegal <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      if (state == ISSUE) issued <= fifo_head;
      // Clearing on WAIT_DONE entry wins over a capture landing on the same edge.
      if (wd_enter)        cap_cnt <= 7'd0;
      else if (IRAM_valid) cap_cnt <= cap_cnt + 7'd1;
      if (push && !is_legal(cmd_in))       err_illegal <= 1'b1;
      if (done_hit)                        seq_done    <= 1'b1;
      if (done_hit && cap_cnt != CAP_FULL) err_short   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_host.sv
module tb_lcd_host;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       img_wr_en = 1'b0;
  logic [5:0] img_wr_addr = '0;
  logic [7:0] img_wr_data = '0;
  logic [3:0] cmd_in = '0;
  logic       cmd_in_valid = 1'b0;
  logic       cmd_in_ready;
  logic       start = 1'b0;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       seq_done;
  logic       err_illegal;
  logic       err_short;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       IROM_rd = 1'b0;
  logic [5:0] IROM_A = '0;
  logic [7:0] IROM_Q;
  logic       IRAM_valid = 1'b0;
  logic [5:0] IRAM_A = '0;
  logic [7:0] IRAM_D = '0;

  lcd_host #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .img_wr_en    (img_wr_en),
    .img_wr_addr  (img_wr_addr),
    .img_wr_data  (img_wr_data),
    .cmd_in       (cmd_in),
    .cmd_in_valid (cmd_in_valid),
    .cmd_in_ready (cmd_in_ready),
    .start        (start),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .seq_done     (seq_done),
    .err_illegal  (err_illegal),
    .err_short    (err_short),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .busy         (busy),
    .done         (done),
    .IROM_rd      (IROM_rd),
    .IROM_A       (IROM_A),
    .IROM_Q       (IROM_Q),
    .IRAM_valid   (IRAM_valid),
    .IRAM_A       (IRAM_A),
    .IRAM_D       (IRAM_D)
  );

  always #5 clk = ~clk;

  // Reference state: memories, FIFO occupancy/contents, expected sticky flag.
  logic [7:0] rom_m [64];
  logic [7:0] res_m [64];
  logic [3:0] exp_q [$];
  int         occ = 0;
  logic       exp_ill = 1'b0;

  int checks = 0;
  int errors = 0;

  // Controller-side observer: records every issued command and protocol slips.
  logic [3:0] got [$];
  int   spacing_bad = 0;
  int   busy_bad = 0;
  int   idle_bad = 0;
  logic prev_valid = 1'b0;
  logic prev_busy = 1'b0;
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_valid === 1'b1) begin
        got.push_back(cmd);
        if (prev_valid) spacing_bad <= spacing_bad + 1;
        if (prev_busy)  busy_bad <= busy_bad + 1;
      end else if (cmd_valid !== 1'b0 || cmd !== 4'h0) begin
        idle_bad <= idle_bad + 1;
      end
    end
    prev_valid <= (cmd_valid === 1'b1);
    prev_busy  <= busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; cmd_in_valid = 1'b0; cmd_in = '0;
    busy = 1'b0; done = 1'b0; IRAM_valid = 1'b0; img_wr_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    occ = 0;
    exp_ill = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [3:0] code);
    cmd_in = code;
    cmd_in_valid = 1'b1;
    chk("cmd_in_ready", 32'(cmd_in_ready), 32'(occ < DEPTH));
    if (occ < DEPTH) begin
      if (code > 4'd11) exp_ill = 1'b1;
      else begin
        occ++;
        exp_q.push_back(code);
      end
    end
    tick();
    cmd_in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int base, input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < base + n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(got.size() - base), 32'(n));
  endtask

  task automatic iram_burst(input int k, input logic rnd);
    for (int i = 0; i < k; i++) begin
      IRAM_valid = 1'b1;
      IRAM_A = rnd ? 6'($urandom_range(0, 63)) : 6'(i);
      IRAM_D = rnd ? 8'($urandom) : ~8'(i);
      res_m[IRAM_A] = IRAM_D;
      tick();
    end
    IRAM_valid = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    int k;
    logic has_wr;
    logic [3:0] exp_iss [$];
    logic [3:0] code;

    // Reset state.
    do_reset();
    mon_en = 1'b1;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    chk("rst_cmd", 32'(cmd), 32'(0));
    chk("rst_ready", 32'(cmd_in_ready), 32'(1));
    chk("rst_flags", 32'({seq_done, err_illegal, err_short}), 32'(0));

    // Image ROM: identity load then zero-latency reads.
    for (int i = 0; i < 64; i++) begin
      img_wr_en = 1'b1; img_wr_addr = 6'(i); img_wr_data = 8'(i);
      rom_m[i] = 8'(i);
      tick();
    end
    img_wr_en = 1'b0;
    IROM_rd = 1'b1; IROM_A = 6'd37; #1;
    chk("irom_37", 32'(IROM_Q), 32'(37));
    IROM_rd = 1'b0; #1;
    chk("irom_rd0", 32'(IROM_Q), 32'(0));
    for (int i = 0; i < 64; i++) begin
      img_wr_en = 1'b1; img_wr_addr = 6'(i); img_wr_data = 8'($urandom);
      rom_m[i] = img_wr_data;
      tick();
    end
    img_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      IROM_rd = 1'b1; IROM_A = 6'($urandom_range(0, 63)); #1;
      chk("irom_rand", 32'(IROM_Q), 32'(rom_m[IROM_A]));
    end
    IROM_rd = 1'b0;

    // Illegal code dropped; an empty FIFO stalls silently.
    do_reset();
    base = got.size();
    push(4'd13);
    chk("err_illegal", 32'(err_illegal), 32'(1));
    do_start();
    for (int i = 0; i < 10; i++) tick();
    chk("empty_stall", 32'(got.size() - base), 32'(0));
    chk("stall_no_err", 32'({seq_done, err_short}), 32'(0));

    // Depth limit: ninth push refused, only eight issued in order.
    do_reset();
    base = got.size();
    for (int i = 0; i < 8; i++) push(4'($urandom_range(1, 11)));
    chk("full_ready", 32'(cmd_in_ready), 32'(0));
    push(4'd7);
    do_start();
    wait_pulses(base, 8, 200, "full_issue_cnt");
    for (int i = 0; i < 10; i++) tick();
    chk("full_no_ninth", 32'(got.size() - base), 32'(8));
    for (int i = 0; i < 8; i++) chk("full_order", 32'(got[base + i]), 32'(exp_q[i]));

    // Sequence 1,4,5,0 then a full 64-pixel capture.
    do_reset();
    base = got.size();
    push(4'd1); push(4'd4); push(4'd5); push(4'd0);
    do_start();
    wait_pulses(base, 4, 100, "seq4_cnt");
    for (int i = 0; i < 4; i++) chk("seq4_order", 32'(got[base + i]), 32'(exp_q[i]));
    occ = 0;
    tick();
    iram_burst(64, 1'b0);
    pulse_done();
    chk("seq_done", 32'(seq_done), 32'(1));
    chk("err_short_64", 32'(err_short), 32'(0));
    rd_addr = 6'd5; #1;
    chk("rd_5", 32'(rd_data), 32'(8'hFA));
    push(4'd3);
    for (int i = 0; i < 10; i++) tick();
    chk("finish_no_issue", 32'(got.size() - base), 32'(4));
    chk("finish_sticky", 32'(seq_done), 32'(1));

    // Busy held for 10 cycles after a pulse.
    do_reset();
    rd_addr = 6'd5; #1;
    chk("res_kept", 32'(rd_data), 32'(res_m[5]));
    base = got.size();
    push(4'd2); push(4'd3);
    do_start();
    wait_pulses(base, 1, 50, "busy_first");
    chk("busy_first_cmd", 32'(got[base]), 32'(2));
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("busy_hold", 32'(cmd_valid), 32'(0));
    end
    busy = 1'b0;
    chk("busy_fall_cycle", 32'(cmd_valid), 32'(0));
    tick();
    chk("busy_after_fall", 32'({cmd_valid, cmd}), 32'({1'b1, 4'd3}));

    // Short capture (63 pixels).
    do_reset();
    base = got.size();
    push(4'd0);
    do_start();
    wait_pulses(base, 1, 50, "short_issue");
    tick();
    iram_burst(63, 1'b0);
    pulse_done();
    chk("err_short_63", 32'(err_short), 32'(1));
    chk("seq_done_63", 32'(seq_done), 32'(1));

    // Reset mid-sequence aborts further issue.
    do_reset();
    base = got.size();
    push(4'd1); push(4'd2); push(4'd3);
    do_start();
    wait_pulses(base, 1, 50, "abort_first");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", 32'({cmd_in_ready, cmd_valid, cmd}), 32'({1'b1, 1'b0, 4'd0}));
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_more", 32'(got.size() - base), 32'(1));
    IROM_rd = 1'b1; IROM_A = 6'd9; #1;
    chk("rom_kept", 32'(IROM_Q), 32'(rom_m[9]));
    IROM_rd = 1'b0;

    // Randomized command lists with random busy.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      base = got.size();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        code = 4'($urandom_range(0, 15));
        push(code);
      end
      chk("rnd_illegal", 32'(err_illegal), 32'(exp_ill));
      exp_iss.delete();
      has_wr = 1'b0;
      foreach (exp_q[i]) begin
        if (!has_wr) begin
          exp_iss.push_back(exp_q[i]);
          if (exp_q[i] == 4'd0) has_wr = 1'b1;
        end
      end
      do_start();
      k = 0;
      while (got.size() - base < exp_iss.size() && k < 400) begin
        busy = ($urandom_range(0, 2) == 0);
        tick();
        k++;
      end
      busy = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("rnd_cnt", 32'(got.size() - base), 32'(exp_iss.size()));
      for (int i = 0; i < exp_iss.size() && base + i < got.size(); i++)
        chk("rnd_order", 32'(got[base + i]), 32'(exp_iss[i]));
      if (has_wr) begin
        k = $urandom_range(62, 66);
        iram_burst(k, 1'b1);
        pulse_done();
        chk("rnd_short", 32'(err_short), 32'(k != 64));
        chk("rnd_done", 32'(seq_done), 32'(1));
        for (int i = 0; i < 3; i++) begin
          rd_addr = 6'($urandom_range(0, 63)); #1;
          chk("rnd_rd", 32'(rd_data), 32'(res_m[rd_addr]));
        end
      end else begin
        chk("rnd_no_done", 32'(seq_done), 32'(0));
      end
    end

    chk("spacing", 32'(spacing_bad), 32'(0));
    chk("busy_respect", 32'(busy_bad), 32'(0));
    chk("idle_outputs", 32'(idle_bad), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_host.md
LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, command FIFO depth (power of two).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports img_wr_en / img_wr_addr / img_wr_data  input  1/6/8  image ROM load port.
REQ-005 The block SHALL have ports cmd_in / cmd_in_valid / cmd_in_ready  input/input/output  4/1/1  command FIFO push handshake.
REQ-006 The block SHALL have port start  input  1  one-cycle pulse that begins command issue.
REQ-007 The block SHALL have ports rd_addr / rd_data  input/output  6/8  combinational readback of the result buffer.
REQ-008 The block SHALL have ports seq_done / err_illegal / err_short  output  1/1/1  sticky status flags.
REQ-009 The block SHALL have ports cmd / cmd_valid  output  4/1  command to the LCD controller.
REQ-010 The block SHALL have ports busy / done  input  1/1  LCD controller status.
REQ-011 The block SHALL have ports IROM_rd / IROM_A / IROM_Q  input/input/output  1/6/8  image-ROM responder.
REQ-012 The block SHALL have ports IRAM_valid / IRAM_A / IRAM_D  input/input/input  1/6/8  result-RAM responder.

Function
REQ-013 The 64x8 image ROM SHALL be written on img_wr_en=1: rom[img_wr_addr] <= img_wr_data.
REQ-014 IROM_Q SHALL be combinational: rom[IROM_A] when IROM_rd=1, else 8'h00 (zero latency).
REQ-015 When IRAM_valid=1, the block SHALL write res[IRAM_A] <= IRAM_D and increment the 7-bit cap_cnt.
REQ-016 rd_data SHALL equal res[rd_addr] combinationally.
REQ-017 A push SHALL occur iff cmd_in_valid=1 and cmd_in_ready=1; cmd_in_ready = FIFO not full.
REQ-018 A cmd_in value of 12-15 SHALL be dropped (not stored) and set err_illegal.
REQ-019 FSM states: IDLE, WAIT_RDY, ISSUE, GUARD, WAIT_DONE, FINISH.
REQ-020 IDLE -> WAIT_RDY on start=1; start in any other state SHALL be ignored.
REQ-021 WAIT_RDY -> ISSUE when busy=0 and the FIFO is non-empty; otherwise remain.
REQ-022 In ISSUE, the FIFO head SHALL be popped, cmd = head, cmd_valid=1 for exactly one cycle; then -> GUARD.
REQ-023 In GUARD, cmd_valid SHALL be 0 for one cycle; then -> WAIT_DONE if the issued code was 0 (Write), else -> WAIT_RDY.
REQ-024 Outside ISSUE, cmd_valid SHALL be 0 and cmd SHALL be 4'h0.
REQ-025 cap_cnt SHALL clear on entering WAIT_DONE.
REQ-026 WAIT_DONE -> FINISH when done=1; err_short SHALL be set if cap_cnt != 64 at that cycle.
REQ-027 In FINISH, seq_done SHALL be 1 until reset; FIFO pushes remain accepted but are never issued.
REQ-028 A simultaneous push and pop SHALL keep the occupancy unchanged, including when the FIFO is full.
REQ-029 The FIFO empty in WAIT_RDY SHALL stall indefinitely with no error.
REQ-030 IROM and IRAM service SHALL be independent of FSM state.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, FIFO empty, cap_cnt=0, and all flags 0.
REQ-032 Reset SHALL leave cmd_valid=0, cmd=0 and cmd_in_ready=1 in the following cycle.
REQ-033 Reset mid-sequence SHALL abort without emitting any further cmd_valid pulse.
REQ-034 ROM and result buffer contents SHALL NOT be reset.

Structure
REQ-035 Package lcd_pkg SHALL hold command codes 0-11 (WRITE=0 ... MIRROR_Y=11) and CMD_MAX=11.
REQ-036 The FIFO SHALL be a sub-module named lcd_cmd_fifo (width 4, depth FIFO_DEPTH).

Verification
REQ-037 Load rom[i]=i, then drive IROM_rd=1 with IROM_A=37 -> IROM_Q=8'd37 in the same cycle; with IROM_rd=0 -> IROM_Q=8'h00.
REQ-038 Push {1,4,5,0}, start, busy model low -> four single-cycle cmd_valid pulses with cmd 1,4,5,0, each pulse separated by at least one idle cycle.
REQ-039 Hold busy=1 for 10 cycles after a pulse -> no new cmd_valid until the cycle after busy falls.
REQ-040 Issue Write, drive 64 IRAM writes res[i]=~i, then done=1 -> seq_done=1, err_short=0, rd_addr=5 gives 8'hFA.
REQ-041 Issue Write, drive only 63 IRAM writes, then done=1 -> err_short=1.
REQ-042 Push 13 -> err_illegal=1 and FIFO empty; push 9 items with depth 8 -> 9th not accepted and cmd_in_ready=0.
